// File: rtl/booth4_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier controller.
// BOOTH4_UNSIGNED_EN selects unsigned operands (5 digits) instead of signed (4 digits).
package booth4_pkg;

  localparam int OP_W   = 8;
  localparam int MUL_W  = 10;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 3;

`ifdef BOOTH4_UNSIGNED_EN
  localparam int N_DIGITS = 5;
`else
  localparam int N_DIGITS = 4;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [2:0] digit_t;

  // Slot order of the candidate multiples handed to the digit selector
  localparam int MI_ZERO = 0;
  localparam int MI_A    = 1;
  localparam int MI_2A   = 2;
  localparam int MI_NA   = 3;
  localparam int MI_N2A  = 4;
  typedef logic [4:0][MUL_W-1:0] mults_t;

  function automatic logic [MUL_W-1:0] op_ext(input logic [OP_W-1:0] v);
`ifdef BOOTH4_UNSIGNED_EN
    return {{(MUL_W-OP_W){1'b0}}, v};
`else
    return {{(MUL_W-OP_W){v[OP_W-1]}}, v};
`endif
  endfunction

endpackage

// File: rtl/booth4_digit_sel.sv
// Radix-4 Booth digit recoder: picks one of the precomputed multiples from a bit triplet.
import booth4_pkg::*;

module booth4_digit_sel (
  input  logic [2:0]       trip_i,
  input  mults_t           mults_i,
  output logic [MUL_W-1:0] sel_o
);

  always_comb begin
    sel_o = mults_i[MI_ZERO];
    case (trip_i)
      3'b001, 3'b010: sel_o = mults_i[MI_A];
      3'b011:         sel_o = mults_i[MI_2A];
      3'b100:         sel_o = mults_i[MI_N2A];
      3'b101, 3'b110: sel_o = mults_i[MI_NA];
      default:        sel_o = mults_i[MI_ZERO];
    endcase
  end

endmodule

// File: rtl/booth4_mult_ctrl.sv
// Iterative radix-4 Booth multiplier: one digit per RUN cycle, one-cycle done pulse.
// Build option BOOTH4_UNSIGNED_EN switches to unsigned operands with one extra digit.
import booth4_pkg::*;

module booth4_mult_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  state_e             state_q, state_d;
  logic [MUL_W-1:0]   a_q;
  logic [MUL_W:0]     b_q;       // extended multiplier with the implicit b[-1]=0 at bit 0
  logic [CNT_W-1:0]   cnt_q;
  logic [PROD_W-1:0]  acc_q;
  logic [PROD_W-1:0]  product_q;

  logic               accept;
  logic               last;
  digit_t             trip;
  mults_t             mults;
  logic [MUL_W-1:0]   sel;
  logic [PROD_W-1:0]  addend;
  logic [PROD_W-1:0]  acc_sum;

  assign accept = start && (state_q != ST_RUN);
  assign last   = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last)  state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  // Multiples derive from the latched operand only, so they stay fixed for the whole run
  assign mults[MI_ZERO] = '0;
  assign mults[MI_A]    = a_q;
  assign mults[MI_2A]   = {a_q[MUL_W-2:0], 1'b0};
  assign mults[MI_NA]   = -a_q;
  assign mults[MI_N2A]  = -{a_q[MUL_W-2:0], 1'b0};

  assign trip = b_q[{cnt_q, 1'b0} +: 3];

  booth4_digit_sel u_sel (
    .trip_i  (trip),
    .mults_i (mults),
    .sel_o   (sel)
  );

  assign addend  = {{(PROD_W-MUL_W){sel[MUL_W-1]}}, sel} << {cnt_q, 1'b0};
  assign acc_sum = acc_q + addend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else if (accept) begin
      a_q   <= op_ext(a);
      b_q   <= {op_ext(b), 1'b0};
      cnt_q <= '0;
      acc_q <= '0;
    end else if (state_q == ST_RUN) begin
      acc_q <= acc_sum;
      cnt_q <= cnt_q + 1'b1;
      if (last) product_q <= acc_sum;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth4_mult_ctrl.sv
// Self-checking bench for booth4_mult_ctrl: vector table, directed corner sequences, random ops.
`timescale 1ns/1ps
module tb_booth4_mult_ctrl;

`ifdef BOOTH4_UNSIGNED_EN
  localparam int N = 5;
`else
  localparam int N = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;
  vec_t vecs[$];

  booth4_mult_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
`ifdef BOOTH4_UNSIGNED_EN
    int ux = int'(x);
    int uy = int'(y);
    return 16'(ux * uy);
`else
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    return 16'(sx * sy);
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Presents operands with start for one edge; returns #1 after the accepting edge (cycle 1).
  task automatic accept_op(input logic [7:0] ia, input logic [7:0] ib);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
  endtask

  // Waits for done starting from cycle c0; reports the cycle on which done rose.
  task automatic wait_done(input int c0, output int lat, output bit bok);
    lat = c0; bok = 1'b1;
    while (!done && lat < 30) begin
      if (!busy) bok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] exp, input string nm);
    int lat; bit bok;
    accept_op(ia, ib);
    wait_done(1, lat, bok);
    check({nm, " latency"}, lat, N + 1);
    check({nm, " busy"}, {bok, busy}, 2'b10);
    check({nm, " product"}, product, exp);
    @(posedge clk); #1;
    check({nm, " done drop"}, {done, busy}, 2'b00);
    check({nm, " hold"}, product, exp);
  endtask

  initial begin
    int lat; bit bok; bit seen;
    logic [7:0] ra, rb;

`ifdef BOOTH4_UNSIGNED_EN
    vecs.push_back('{8'd255, 8'd255, 16'hFE01});
    vecs.push_back('{8'd128, 8'd2,   16'h0100});
    vecs.push_back('{8'd7,   8'd3,   16'h0015});
    vecs.push_back('{8'd0,   8'd255, 16'h0000});
    vecs.push_back('{8'd255, 8'd1,   16'h00FF});
    vecs.push_back('{8'd200, 8'd170, 16'h84D0});
`else
    vecs.push_back('{8'd7,   8'd3,   16'h0015});
    vecs.push_back('{8'h80,  8'h80,  16'h4000});
    vecs.push_back('{8'h80,  8'h7F,  16'hC080});
    vecs.push_back('{8'h00,  8'hFF,  16'h0000});
    vecs.push_back('{8'h7F,  8'h7F,  16'h3F01});
    vecs.push_back('{8'hFF,  8'hFF,  16'h0001});
    vecs.push_back('{8'h01,  8'h80,  16'hFF80});
    vecs.push_back('{8'hF9,  8'h05,  16'hFFDD});
`endif

    // start during reset must be ignored
    start = 1'b1; a = 8'd9; b = 8'd9;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {busy, done, product}, 18'h0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle after reset", {busy, done}, 2'b00);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    // start re-asserted mid-run with different operands is ignored
    accept_op(8'd7, 8'd3);
    @(posedge clk); #1;
    start = 1'b1; a = 8'd100; b = 8'hFB;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, lat, bok);
    check("ignore latency", lat, N + 1);
    check("ignore product", product, 16'h0015);
    @(posedge clk); #1;

    // back-to-back: second op accepted on the DONE edge
    accept_op(8'd7, 8'd3);
    wait_done(1, lat, bok);
    check("b2b first", product, 16'h0015);
    a = 8'hF7; b = 8'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b rerun busy", {busy, done}, 2'b10);
    check("b2b product held", product, 16'h0015);
    wait_done(1, lat, bok);
    check("b2b latency", lat, N + 1);
    check("b2b product", product, ref_mul(8'hF7, 8'd11));
    @(posedge clk); #1;

    // reset mid-run abandons the operation; start with reset is ignored
    accept_op(8'd50, 8'd60);
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    check("midrst state", {busy, done, product}, 18'h0);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("midrst no done", seen, 1'b0);
    run_op(8'd12, 8'd13, ref_mul(8'd12, 8'd13), "post reset");

    for (int k = 0; k < 40; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, ref_mul(ra, rb), $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
